// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encodings and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/fullAdder.sv
// Shared 1-bit full-adder cell, purely combinational.
module fullAdder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: walks one shared full adder across two WIDTH-bit operands, LSB first,
// chaining the carry through a flip-flop between bits.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE; busy covers RUN and DONE, and
    // start is dropped (not queued) while busy. done is a single-cycle strobe in
    // DONE, and sum/cout then hold until the next accepted start.

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             fa_sum;
    logic             fa_cout;

    fullAdder u_fa (
        .x    (sa[0]),
        .y    (sb[0]),
        .cin  (c),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                    sum <= {fa_sum, sum[WIDTH-1:1]};
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    c   <= fa_cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign cout      = c;
    assign dbg_state = state;

endmodule
